// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the word for decode and selects the next PC when it is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        PCsrc,
  input  logic        reg_jump,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic        err_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc_d;
  logic        next_misaligned;
  logic        consume;
  logic        unused_alu_lsb;

  assign pc_plus4       = pc_q + 32'd4;
  assign consume        = (state_q == HOLD) && !stall;
  assign unused_alu_lsb = ALUResult[0];

  always_comb begin
    next_pc_d = pc_plus4;
    if (PCsrc) begin
      if (reg_jump) next_pc_d = {ALUResult[31:1], 1'b0};
      else          next_pc_d = pc_q + ImmExt;
    end
  end

  // JALR clears only bit 0, so bit 1 can still make the target misaligned.
  assign next_misaligned = (next_pc_d[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (req_q && imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            valid_q <= 1'b0;
            if (next_misaligned) begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign Instr        = instr_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at RESET_PC = 0, one at the
// top of the address space for the wrap case.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, stall, PCsrc, reg_jump;
  logic [31:0] imem_rdata, ImmExt, ALUResult;
  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, Instr, PC, PCPlus4;

  logic        rst1, ack1, stall1;
  logic        req1, valid1, err1;
  logic [31:0] addr1, instr1, pc1, pcp4_1;

  int unsigned n_eval = 0;
  int unsigned n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .instr_valid(instr_valid), .stall(stall),
    .PC(PC), .PCPlus4(PCPlus4),
    .PCsrc(PCsrc), .reg_jump(reg_jump), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst(rst1),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(32'h0000_0013),
    .Instr(instr1), .instr_valid(valid1), .stall(stall1),
    .PC(pc1), .PCPlus4(pcp4_1),
    .PCsrc(1'b0), .reg_jump(1'b0), .ImmExt(32'h0), .ALUResult(32'h0),
    .misalign_err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle ack while in REQ at the expected address.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    check("req_before_ack", {31'b0, imem_req}, 32'd1);
    check("addr_before_ack", imem_addr, addr);
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("instr_after_ack", Instr, word);
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("req_after_ack", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic consume(input logic src, input logic rj, input logic [31:0] imm,
                         input logic [31:0] alu, input logic [31:0] exp_addr);
    stall = 1'b0; PCsrc = src; reg_jump = rj; ImmExt = imm; ALUResult = alu;
    tick();
    stall = 1'b1; PCsrc = 1'b0; reg_jump = 1'b0;
    check("redirect_addr", imem_addr, exp_addr);
    check("redirect_req", {31'b0, imem_req}, 32'd1);
    check("valid_cleared", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b1; PCsrc = 1'b0; reg_jump = 1'b0;
    imem_rdata = '0; ImmExt = '0; ALUResult = '0;
    rst1 = 1'b1; ack1 = 1'b0; stall1 = 1'b1;
    tick(); tick();

    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc", PC, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);

    rst = 1'b0;
    tick();
    check("first_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("req_held_no_ack", {31'b0, imem_req}, 32'd1);
    check("valid_no_ack", {31'b0, instr_valid}, 32'd0);
    fetch(32'h0, 32'h0050_0093);
    check("pc_first", PC, 32'h0);
    check("pcplus4_first", PCPlus4, 32'h4);

    // Stall three cycles; a stray ack in HOLD must not disturb Instr.
    for (int unsigned i = 0; i < 3; i++) begin
      imem_ack = (i == 1); imem_rdata = 32'hDEAD_BEEF;
      tick();
      check("stall_instr", Instr, 32'h0050_0093);
      check("stall_pc", PC, 32'h0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

    fetch(32'h4, 32'h0000_0013); consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
    fetch(32'h8, 32'h0000_0013); consume(1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
    fetch(32'hC, 32'h0000_0013); consume(1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
    fetch(32'h10, 32'hFE00_0CE3);
    consume(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h8);
    fetch(32'h8, 32'h0000_8067);
    consume(1'b1, 1'b1, 32'h0, 32'h0000_0101, 32'h100);
    fetch(32'h100, 32'hF200_006F);
    consume(1'b1, 1'b0, 32'hFFFF_FF20, 32'h0, 32'h20);
    fetch(32'h20, 32'h0060_0063);

    stall = 1'b0; PCsrc = 1'b1; reg_jump = 1'b0; ImmExt = 32'h6;
    tick();
    stall = 1'b1; PCsrc = 1'b0;
    check("halt_err", {31'b0, misalign_err}, 32'd1);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_pc", PC, 32'h20);
    for (int unsigned i = 0; i < 10; i++) begin
      imem_ack = i[0]; stall = i[1];
      tick();
      check("halt_no_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0; stall = 1'b1;
    check("halt_pc_held", PC, 32'h20);
    check("halt_err_sticky", {31'b0, misalign_err}, 32'd1);

    rst = 1'b1;
    tick();
    check("rst_clears_err", {31'b0, misalign_err}, 32'd0);
    check("rst_pc_reload", PC, 32'h0);
    rst = 1'b0;
    tick();
    check("refetch_req", {31'b0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, 32'h0);

    // Reset mid-REQ with a coincident ack: the ack is discarded.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    check("rstack_valid", {31'b0, instr_valid}, 32'd0);
    check("rstack_instr", Instr, 32'h0);
    check("rstack_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("rstack_req_again", {31'b0, imem_req}, 32'd1);

    // Address-space wrap on the second instance.
    check("top_rst_pc", pc1, 32'hFFFF_FFFC);
    check("top_pcplus4", pcp4_1, 32'h0);
    rst1 = 1'b0;
    tick();
    check("top_req", {31'b0, req1}, 32'd1);
    check("top_addr", addr1, 32'hFFFF_FFFC);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("top_valid", {31'b0, valid1}, 32'd1);
    stall1 = 1'b0;
    tick();
    stall1 = 1'b1;
    check("top_wrap_addr", addr1, 32'h0);
    check("top_wrap_req", {31'b0, req1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
